fft_frame_feeder: RTL

- Transmit-side source for the FFT/Absolute_Magnitude chain.
- Collects real-valued 32-bit float audio samples into FRAME_LEN-sample frames using two ping-pong banks.
- Per frame, issues one FFT config word, then streams the frame on the FFT s_axis_data interface as 64-bit complex beats {Im=0, Re=sample}, with tlast on the final beat.
- Replaces the hand-driven frame stimulus currently used in front of the FFT core.

---
 rtl/fft_frame_feeder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fft_frame_feeder.sv
// Frame source for the FFT / magnitude chain.
//
// Collects real-valued float samples into FRAME_LEN-sample frames using two ping-pong banks.
// For every complete frame it sends one FFT config word and then streams the frame as complex
// beats {Im = 0, Re = sample}, with tlast on the final beat.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_smp_*           sample input stream (tdata DATA_W, tvalid, tready)
//   m_axis_config_*        FFT config stream (tdata 16 = CFG_WORD, tvalid, tready)
//   m_axis_data_*          FFT data stream (tdata 2*DATA_W, tvalid, tready, tlast)
//   frame_count            frames fully sent since reset, wraps at 16 bits
module fft_frame_feeder #(
  parameter int unsigned FRAME_LEN = 128,
  parameter int unsigned DATA_W    = 32,
  parameter logic [15:0] CFG_WORD  = 16'h0003
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DATA_W-1:0]   s_axis_smp_tdata,
  input  logic                s_axis_smp_tvalid,
  output logic                s_axis_smp_tready,
  output logic [15:0]         m_axis_config_tdata,
  output logic                m_axis_config_tvalid,
  input  logic                m_axis_config_tready,
  output logic [2*DATA_W-1:0] m_axis_data_tdata,
  output logic                m_axis_data_tvalid,
  input  logic                m_axis_data_tready,
  output logic                m_axis_data_tlast,
  output logic [15:0]         frame_count
);

  localparam int unsigned     IdxW    = $clog2(FRAME_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCfg, StStream} state_e;

  state_e          state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic [15:0]     frame_count_q, frame_count_d;

  logic [DATA_W-1:0] bank_mem [2][FRAME_LEN];

  logic smp_fire;
  logic wr_done;
  logic rd_done;

  // Forced low during reset so no sample is accepted while state is being cleared.
  assign s_axis_smp_tready = aresetn && !full_q[wr_bank_q];
  assign smp_fire          = s_axis_smp_tvalid && s_axis_smp_tready;
  assign wr_done           = smp_fire && (wr_idx_q == LastIdx);
  assign rd_done           = (state_q == StStream) && m_axis_data_tready && (rd_idx_q == LastIdx);
  assign frame_count       = frame_count_q;

  // Write side: fill the current bank, then hand it over and move to the other one.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (smp_fire) begin
      if (wr_idx_q == LastIdx) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IdxW'(1);
      end
    end
  end

  // A write can only target an empty bank and a read only a full one, so the two updates
  // never collide on the same flag.
  always_comb begin
    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
  end

  always_comb begin
    state_d              = state_q;
    rd_idx_d             = rd_idx_q;
    rd_bank_d            = rd_bank_q;
    frame_count_d        = frame_count_q;
    m_axis_config_tvalid = 1'b0;
    m_axis_config_tdata  = '0;
    m_axis_data_tvalid   = 1'b0;
    m_axis_data_tdata    = '0;
    m_axis_data_tlast    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Look at the completing write too, so config goes out the cycle after the last sample.
        if (full_q[rd_bank_q] || (wr_done && (wr_bank_q == rd_bank_q))) begin
          state_d = StCfg;
        end
      end
      StCfg: begin
        m_axis_config_tvalid = 1'b1;
        m_axis_config_tdata  = CFG_WORD;
        if (m_axis_config_tready) begin
          state_d  = StStream;
          rd_idx_d = '0;
        end
      end
      StStream: begin
        m_axis_data_tvalid = 1'b1;
        m_axis_data_tdata  = {{DATA_W{1'b0}}, bank_mem[rd_bank_q][rd_idx_q]};
        m_axis_data_tlast  = (rd_idx_q == LastIdx);
        if (m_axis_data_tready) begin
          if (rd_idx_q == LastIdx) begin
            rd_idx_d      = '0;
            rd_bank_d     = ~rd_bank_q;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = StIdle;
          end else begin
            rd_idx_d = rd_idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Sample storage needs no reset; the full flags define which contents are meaningful.
  always_ff @(posedge aclk) begin
    if (smp_fire) begin
      bank_mem[wr_bank_q][wr_idx_q] <= s_axis_smp_tdata;
    end
  end

endmodule
